// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_ctrl
// Description : Operand forwarding select, load-use / multi-cycle scoreboard
//               stall generation and stall-cycle statistics for an in-order pipe.
// Revision    : 1.0
// ============================================================================
module hazard_forward_ctrl #(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 2,
    parameter int AW         = 5,
    parameter int MD_LAT     = 4,
    localparam int SW        = $clog2(NUM_STAGES + 1)
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [NUM_SRC*AW-1:0]    id_src_addr,
    input  logic [NUM_SRC-1:0]       id_src_valid,
    input  logic [NUM_SRC*AW-1:0]    ex_src_addr,
    input  logic [NUM_SRC-1:0]       ex_src_valid,
    input  logic [NUM_STAGES*AW-1:0] stg_waddr,
    input  logic [NUM_STAGES-1:0]    stg_we,
    input  logic [AW-1:0]            ex_waddr,
    input  logic                     ex_memread,
    input  logic                     md_issue,
    input  logic [AW-1:0]            md_dest,
    output logic [NUM_SRC*SW-1:0]    fwd_sel,
    output logic                     stall,
    output logic                     md_done,
    output logic [AW-1:0]            md_wb_addr,
    output logic [15:0]              stall_count
);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_BUSY = 1'b1;
    localparam logic [3:0] c_CNT_INIT = 4'(MD_LAT - 1);

    logic [0:0]    r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_sbDest;
    logic          r_mdDone;
    logic [AW-1:0] r_mdWbAddr;
    logic [15:0]   r_stallCount;

    logic w_busy;
    logic w_loadUse;
    logic w_sbHazard;
    logic w_structHazard;
    logic w_accept;

    // Scoreboard is seen as idle while reset is held so nothing stalls on a dying op.
    assign w_busy = (r_state == c_S_BUSY) && !Rst;

    // Scan slots from farthest to nearest so the nearest producer wins.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (ex_src_valid[i] && stg_we[k]
                    && (stg_waddr[k*AW +: AW] != '0)
                    && (stg_waddr[k*AW +: AW] == ex_src_addr[i*AW +: AW])) begin
                    fwd_sel[i*SW +: SW] = SW'(k + 1);
                end
            end
        end
    end

    always_comb begin
        w_loadUse  = 1'b0;
        w_sbHazard = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_valid[i] && ex_memread && (ex_waddr != '0)
                && (ex_waddr == id_src_addr[i*AW +: AW])) begin
                w_loadUse = 1'b1;
            end
            if (id_src_valid[i] && w_busy && (r_sbDest != '0)
                && (r_sbDest == id_src_addr[i*AW +: AW])) begin
                w_sbHazard = 1'b1;
            end
        end
    end

    assign w_structHazard = md_issue && w_busy;
    assign stall          = w_loadUse || w_sbHazard || w_structHazard;
    assign w_accept       = md_issue && !w_busy && !w_loadUse && !w_sbHazard && !Rst;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= c_S_IDLE;
            r_cnt      <= 4'd0;
            r_sbDest   <= '0;
            r_mdDone   <= 1'b0;
            r_mdWbAddr <= '0;
        end else begin
            r_mdDone <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_state  <= c_S_BUSY;
                        r_cnt    <= c_CNT_INIT;
                        r_sbDest <= md_dest;
                    end
                end
                c_S_BUSY: begin
                    // Leaving BUSY here makes the next cycle the result-write cycle.
                    if (r_cnt == 4'd1) begin
                        r_state    <= c_S_IDLE;
                        r_cnt      <= 4'd0;
                        r_mdDone   <= 1'b1;
                        r_mdWbAddr <= r_sbDest;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_stallCount <= 16'd0;
        end else if (stall && (r_stallCount != 16'hFFFF)) begin
            r_stallCount <= r_stallCount + 16'd1;
        end
    end

    assign md_done     = r_mdDone;
    assign md_wb_addr  = r_mdWbAddr;
    assign stall_count = r_stallCount;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_forward_ctrl
// Description : Directed self-checking bench for hazard_forward_ctrl.
// Revision    : 1.0
// ============================================================================
module tb_hazard_forward_ctrl;

    localparam int c_AW = 5;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [9:0]  id_src_addr;
    logic [1:0]  id_src_valid;
    logic [9:0]  ex_src_addr;
    logic [1:0]  ex_src_valid;
    logic [9:0]  stg_waddr;
    logic [1:0]  stg_we;
    logic [4:0]  ex_waddr;
    logic        ex_memread;
    logic        md_issue;
    logic [4:0]  md_dest;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic        md_done;
    logic [4:0]  md_wb_addr;
    logic [15:0] stall_count;

    int errors = 0;
    int checks = 0;

    hazard_forward_ctrl #(.NUM_SRC(2), .NUM_STAGES(2), .AW(c_AW), .MD_LAT(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .id_src_addr(id_src_addr), .id_src_valid(id_src_valid),
        .ex_src_addr(ex_src_addr), .ex_src_valid(ex_src_valid),
        .stg_waddr(stg_waddr), .stg_we(stg_we),
        .ex_waddr(ex_waddr), .ex_memread(ex_memread),
        .md_issue(md_issue), .md_dest(md_dest),
        .fwd_sel(fwd_sel), .stall(stall), .md_done(md_done),
        .md_wb_addr(md_wb_addr), .stall_count(stall_count)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Rst = 1'b1;
        id_src_addr = '0; id_src_valid = '0;
        ex_src_addr = '0; ex_src_valid = '0;
        stg_waddr = '0; stg_we = '0;
        ex_waddr = '0; ex_memread = 1'b0;
        md_issue = 1'b0; md_dest = '0;
        step(); step();
        Rst = 1'b0;
        #1;
        chk("rst_md_done", 32'(md_done), 0);
        chk("rst_wb_addr", 32'(md_wb_addr), 0);
        chk("rst_stall_count", 32'(stall_count), 0);
        chk("rst_stall", 32'(stall), 0);

        // Forwarding priority and register-0 exclusion
        stg_waddr = {5'd8, 5'd8}; stg_we = 2'b11;
        ex_src_addr = {5'd3, 5'd8}; ex_src_valid = 2'b11;
        #1 chk("fwd_both_slots", 32'(fwd_sel), 32'h1);
        stg_we = 2'b10;
        #1 chk("fwd_wb_only", 32'(fwd_sel), 32'h2);
        ex_src_addr = {5'd3, 5'd0};
        #1 chk("fwd_src_r0", 32'(fwd_sel), 32'h0);
        stg_waddr = {5'd0, 5'd0}; stg_we = 2'b11;
        #1 chk("fwd_r0_producer", 32'(fwd_sel), 32'h0);
        stg_waddr = {5'd7, 5'd8}; ex_src_addr = {5'd7, 5'd8}; ex_src_valid = 2'b01;
        #1 chk("fwd_src1_invalid", 32'(fwd_sel), 32'h1);
        ex_src_valid = 2'b10;
        #1 chk("fwd_src1_wb", 32'(fwd_sel), 32'h8);
        stg_we = 2'b00; ex_src_valid = 2'b00;

        // Load-use
        ex_memread = 1'b1; ex_waddr = 5'd9;
        id_src_addr = {5'd9, 5'd4}; id_src_valid = 2'b10;
        #1 chk("lu_stall", 32'(stall), 1);
        step();
        chk("lu_count", 32'(stall_count), 1);
        id_src_valid = 2'b00;
        #1 chk("lu_invalid_src", 32'(stall), 0);
        step();
        chk("lu_count_hold", 32'(stall_count), 1);
        ex_waddr = 5'd0; id_src_addr = '0; id_src_valid = 2'b11;
        #1 chk("lu_r0", 32'(stall), 0);
        ex_memread = 1'b0; id_src_valid = 2'b00;
        Rst = 1'b1; step(); Rst = 1'b0;

        // Scoreboard hazard, MD_LAT=4
        id_src_addr = {5'd0, 5'd5}; id_src_valid = 2'b01;
        md_issue = 1'b1; md_dest = 5'd5;
        #1 chk("sb_T_stall", 32'(stall), 0);
        step(); md_issue = 1'b0;
        #1 chk("sb_T1_stall", 32'(stall), 1);
        chk("sb_T1_done", 32'(md_done), 0);
        step(); chk("sb_T2_stall", 32'(stall), 1);
        step(); chk("sb_T3_stall", 32'(stall), 1);
        step();
        chk("sb_T4_done", 32'(md_done), 1);
        chk("sb_T4_wb", 32'(md_wb_addr), 5);
        chk("sb_T4_stall", 32'(stall), 0);
        chk("sb_T4_count", 32'(stall_count), 3);
        step();
        chk("sb_T5_done", 32'(md_done), 0);
        chk("sb_T5_wb_hold", 32'(md_wb_addr), 5);

        // Structural hazard and back-to-back issue
        id_src_valid = 2'b00;
        md_issue = 1'b1; md_dest = 5'd6;
        step(); md_dest = 5'd7;
        #1 chk("st_T1_stall", 32'(stall), 1);
        step(); chk("st_T2_stall", 32'(stall), 1);
        step(); chk("st_T3_stall", 32'(stall), 1);
        step();
        chk("st_T4_done", 32'(md_done), 1);
        chk("st_T4_wb", 32'(md_wb_addr), 6);
        chk("st_T4_stall", 32'(stall), 0);
        step(); md_issue = 1'b0;
        #1 chk("st_T5_done", 32'(md_done), 0);
        step(); step();
        chk("st_T7_done", 32'(md_done), 0);
        step();
        chk("st_T8_done", 32'(md_done), 1);
        chk("st_T8_wb", 32'(md_wb_addr), 7);
        chk("st_count", 32'(stall_count), 6);

        // Reset while busy
        step();
        md_issue = 1'b1; md_dest = 5'd10;
        step(); md_issue = 1'b0;
        step();
        Rst = 1'b1; id_src_addr = {5'd0, 5'd10}; id_src_valid = 2'b01;
        #1 chk("rm_rst_stall", 32'(stall), 0);
        step(); Rst = 1'b0;
        #1 chk("rm_count", 32'(stall_count), 0);
        chk("rm_idle_no_stall", 32'(stall), 0);
        chk("rm_done", 32'(md_done), 0);
        chk("rm_wb", 32'(md_wb_addr), 0);
        id_src_valid = 2'b00; md_issue = 1'b1; md_dest = 5'd11;
        step(); md_issue = 1'b0;
        #1 chk("rm_old_done_T4", 32'(md_done), 0);
        step(); step();
        chk("rm_T6_done", 32'(md_done), 0);
        step();
        chk("rm_T7_done", 32'(md_done), 1);
        chk("rm_T7_wb", 32'(md_wb_addr), 11);

        // Saturation
        ex_memread = 1'b1; ex_waddr = 5'd9;
        id_src_addr = {5'd9, 5'd0}; id_src_valid = 2'b10;
        for (int n = 0; n < 65534; n++) step();
        chk("sat_pre", 32'(stall_count), 32'hFFFE);
        for (int n = 0; n < 4466; n++) step();
        chk("sat_hold", 32'(stall_count), 32'hFFFF);
        ex_memread = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_forward_ctrl.md
HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

Interface
REQ-001 SHALL provide parameter NUM_SRC, default 2: number of source operands per instruction.
REQ-002 SHALL provide parameter NUM_STAGES, default 2: number of forwarding producer stages (slot 0 = MEM, nearest; slot 1 = WB).
REQ-003 SHALL provide parameter AW, default 5: register address width.
REQ-004 SHALL provide parameter MD_LAT, default 4 (legal 2..15): multi-cycle multiply/divide latency in cycles.
REQ-005 SHALL derive localparam SW = clog2(NUM_STAGES+1): forward-select width.
REQ-006 SHALL use one clock and one reset; reset is synchronous and active-high.
REQ-007 Ports SHALL be:
  Clk  in  1  clock, rising edge.
  Rst  in  1  synchronous active-high reset.
  id_src_addr  in  NUM_SRC*AW  ID-stage source registers, source i at bits [i*AW +: AW].
  id_src_valid  in  NUM_SRC  source i is actually read.
  ex_src_addr  in  NUM_SRC*AW  EX-stage source registers.
  ex_src_valid  in  NUM_SRC  EX source i is used as a register operand (0 for immediate operand).
  stg_waddr  in  NUM_STAGES*AW  destination register per producer stage.
  stg_we  in  NUM_STAGES  producer stage writes the register file.
  ex_waddr  in  AW  EX-stage destination register.
  ex_memread  in  1  EX-stage instruction is a load.
  md_issue  in  1  ID requests a multi-cycle op.
  md_dest  in  AW  destination register of the multi-cycle op.
  fwd_sel  out  NUM_SRC*SW  per EX source: 0 = register file, k = stage slot k-1.
  stall  out  1  freeze PC/IF/ID and bubble EX.
  md_done  out  1  one-cycle result-write strobe.
  md_wb_addr  out  AW  destination accompanying md_done.
  stall_count  out  16  saturating count of stall cycles.

Function
REQ-008 fwd_sel[i] SHALL be k+1 for the lowest slot k with stg_we[k]=1, stg_waddr[k]!=0, stg_waddr[k]==ex_src_addr[i] and ex_src_valid[i]=1; otherwise 0. It is combinational with zero latency.
REQ-009 Register 0 SHALL never be forwarded, never cause a stall, and never be marked busy.
REQ-010 Load-use hazard SHALL be asserted when ex_memread=1, ex_waddr!=0, and ex_waddr matches any valid id_src_addr.
REQ-011 The scoreboard SHALL have two states. IDLE: no op outstanding. BUSY: one op outstanding, with a 4-bit down-counter and a captured destination register (sb_dest).
REQ-012 Scoreboard hazard SHALL be asserted when state=BUSY, sb_dest!=0, and sb_dest matches any valid id_src_addr.
REQ-013 Structural hazard SHALL be asserted when md_issue=1 and state=BUSY.
REQ-014 stall SHALL be the combinational OR of the load-use, scoreboard and structural hazards.
REQ-015 An issue SHALL be accepted on the clock edge when md_issue=1, state=IDLE, and neither the load-use nor the scoreboard hazard is asserted. A rejected issue is ignored, and the requester holds md_issue.
REQ-016 On acceptance in cycle T, the block SHALL capture sb_dest=md_dest and enter BUSY. State SHALL be BUSY for cycles T+1 .. T+MD_LAT-1.
REQ-017 In cycle T+MD_LAT, the block SHALL be IDLE with md_done=1 (registered output) and md_wb_addr=sb_dest. md_done SHALL be 0 in all other cycles.
REQ-018 During the md_done cycle, sb_dest SHALL no longer stall ID. The register file is write-first, so ID reads in that cycle get the new value.
REQ-019 An md_issue in the md_done cycle SHALL be accepted (back-to-back issue), giving the next md_done at that cycle plus MD_LAT.
REQ-020 stall_count SHALL increment on each edge where stall=1 and SHALL saturate at 16'hFFFF.
REQ-021 md_wb_addr SHALL hold its last value when md_done=0.

Reset
REQ-022 On a Clk edge with Rst=1, the block SHALL set state=IDLE, counter=0, sb_dest=0, md_done=0, md_wb_addr=0, stall_count=0, discarding any outstanding op, including one reset mid-BUSY.
REQ-023 While Rst=1, md_issue SHALL NOT be accepted. Combinational outputs SHALL continue to follow their inputs, with the scoreboard treated as IDLE.

Verification
REQ-024 Forwarding priority: stg_waddr={8,8}, stg_we=2'b11, ex_src_addr[0]=8 valid -> fwd_sel[0]=1. With stg_we=2'b10 -> fwd_sel[0]=2. With ex_src_addr[0]=0 -> fwd_sel[0]=0.
REQ-025 Load-use: ex_memread=1, ex_waddr=9, id_src_addr[1]=9 valid -> stall=1 for that cycle, stall_count 0->1. With id_src_valid[1]=0 -> stall=0.
REQ-026 Scoreboard (MD_LAT=4): issue md_dest=5 at T, id_src_addr[0]=5 valid -> stall=1 in T+1..T+3, md_done=1 with md_wb_addr=5 at T+4, stall=0 at T+4, stall_count=3.
REQ-027 Structural and back-to-back: second md_issue held from T+1 -> stall=1 T+1..T+3, accepted at T+4, md_done again at T+8.
REQ-028 Reset mid-op: Rst=1 at T+2 -> md_done never pulses, state IDLE, stall_count=0; new issue at T+3 -> md_done at T+7.
REQ-029 Saturation: force stall=1 for 70000 cycles -> stall_count=16'hFFFF, with no wrap.
